// File: rtl/pixel_framer_pkg.sv
// Shared definitions for the pixel framer: geometry defaults, index widths,
// FSM state encoding and the buffered pixel entry layout.
package pixel_framer_pkg;

    localparam int unsigned COL_DEF = 800;
    localparam int unsigned ROW_DEF = 1200;
    localparam int unsigned COL_W   = 10;
    localparam int unsigned ROW_W   = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0]       data;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic             sof;
        logic             eol;
        logic             eof;
    } entry_t;

endpackage

// File: rtl/framer_fifo2.sv
// Two-entry register FIFO holding tagged pixels.
// Ports:
//   Ext_Clk  - clock, rising edge
//   Reset    - synchronous active-high reset, empties the FIFO
//   i_push   - write i_din this cycle (caller guarantees not full)
//   i_pop    - drop the head this cycle (caller guarantees not empty)
//   i_din    - entry to write
//   o_head   - oldest entry, all zeros while empty
//   o_fill   - number of stored entries, 0..2
module framer_fifo2
    import pixel_framer_pkg::*;
(
    input  logic       Ext_Clk,
    input  logic       Reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  entry_t     i_din,
    output entry_t     o_head,
    output logic [1:0] o_fill
);

    entry_t     r_mem0;
    entry_t     r_mem1;
    logic [1:0] r_fill;

    always_ff @(posedge Ext_Clk) begin
        if (Reset) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_fill <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_fill == 2'd0) begin
                        r_mem0 <= i_din;
                    end else begin
                        r_mem1 <= i_din;
                    end
                    r_fill <= r_fill + 2'd1;
                end
                2'b01: begin
                    r_mem0 <= r_mem1;
                    r_fill <= r_fill - 2'd1;
                end
                2'b11: begin
                    // Fill unchanged; new entry lands behind whatever survives the pop.
                    if (r_fill == 2'd1) begin
                        r_mem0 <= i_din;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head = (r_fill != 2'd0) ? r_mem0 : '0;
    assign o_fill = r_fill;

endmodule

// File: rtl/pixel_framer.sv
// Frames an up-sampled pixel stream: tags each accepted pixel with its
// column/row index and sof/eol/eof flags, buffers it in a 2-entry FIFO and
// hands it downstream under valid/ready. A frame_done pulse follows the last
// pixel of each frame once the buffer has drained.
// Ports:
//   Ext_Clk, Reset       - clock and synchronous active-high reset
//   in_valid, in_data    - upstream pixel
//   in_rd_en             - read request to upstream
//   out_ready            - downstream accept
//   out_valid, out_data  - buffered pixel
//   out_col, out_row     - pixel indices
//   out_sof/eol/eof      - frame position flags
//   frame_done           - one-cycle end-of-frame pulse
module pixel_framer
    import pixel_framer_pkg::*;
#(
    parameter int unsigned COL = COL_DEF,
    parameter int unsigned ROW = ROW_DEF
) (
    input  logic             Ext_Clk,
    input  logic             Reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_rd_en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic [COL_W-1:0] out_col,
    output logic [ROW_W-1:0] out_row,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof,
    output logic             frame_done
);

    localparam logic [COL_W-1:0] ColLast = COL_W'(COL - 1);
    localparam logic [ROW_W-1:0] RowLast = ROW_W'(ROW - 1);

    state_t           r_state;
    state_t           w_state_d;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [1:0]       w_fill;
    logic             w_push;
    logic             w_pop;
    logic             w_last_col;
    logic             w_last_px;
    logic             w_frame_done;
    entry_t           w_din;
    entry_t           w_head;

    // Handshake outputs depend only on registered state (plus reset gating).
    assign in_rd_en  = ~Reset & (w_fill != 2'd2) & (r_state != FLUSH);
    assign out_valid = ~Reset & (w_fill != 2'd0);

    assign w_push     = in_valid & in_rd_en;
    assign w_pop      = out_valid & out_ready;
    assign w_last_col = (r_col == ColLast);
    assign w_last_px  = w_last_col & (r_row == RowLast);

    always_comb begin
        w_din      = '0;
        w_din.data = in_data;
        w_din.col  = r_col;
        w_din.row  = r_row;
        w_din.sof  = (r_col == '0) & (r_row == '0);
        w_din.eol  = w_last_col;
        w_din.eof  = w_last_px;
    end

    framer_fifo2 u_fifo (
        .Ext_Clk (Ext_Clk),
        .Reset   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_head  (w_head),
        .o_fill  (w_fill)
    );

    assign out_data = w_head.data;
    assign out_col  = w_head.col;
    assign out_row  = w_head.row;
    assign out_sof  = w_head.sof;
    assign out_eol  = w_head.eol;
    assign out_eof  = w_head.eof;

    always_ff @(posedge Ext_Clk) begin
        if (Reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_push) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_px ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge Ext_Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_state_d = w_last_px ? FLUSH : ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_push && w_last_px) begin
                    w_state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (w_fill == 2'd0) begin
                    w_state_d    = IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    assign frame_done = ~Reset & w_frame_done;

endmodule

// File: tb/tb_pixel_framer.sv
module tb_pixel_framer;

    logic        Ext_Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_rd_en;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [9:0]  out_col;
    logic [10:0] out_row;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    always #5 Ext_Clk = ~Ext_Clk;

    pixel_framer #(
        .COL (4),
        .ROW (3)
    ) dut (
        .Ext_Clk    (Ext_Clk),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_rd_en   (in_rd_en),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_col    (out_col),
        .out_row    (out_row),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .frame_done (frame_done)
    );

    always @(posedge Ext_Clk) begin
        if (frame_done === 1'b1) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Ext_Clk);
        #1;
    endtask

    // Pixel index i of a 4x3 frame sits at col i%4, row i/4.
    task automatic chk_px(input string tag, input int d, input int i);
        int c;
        int r;
        c = i % 4;
        r = i / 4;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data), 32'(d));
        chk({tag, "_col"},   32'(out_col), 32'(c));
        chk({tag, "_row"},   32'(out_row), 32'(r));
        chk({tag, "_sof"},   32'(out_sof), 32'(i == 0));
        chk({tag, "_eol"},   32'(out_eol), 32'(c == 3));
        chk({tag, "_eof"},   32'(out_eof), 32'(i == 11));
    endtask

    // Last pixel was just accepted: block must stop reading, drain, pulse, return to idle.
    task automatic flush_seq(input string tag);
        chk({tag, "_rden_flush"}, 32'(in_rd_en), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        chk({tag, "_done_pulse"}, 32'(frame_done), 32'd1);
        chk({tag, "_empty"},      32'(out_valid), 32'd0);
        chk({tag, "_rden_drain"}, 32'(in_rd_en), 32'd0);
        in_valid = 1'b0;
        tick();
        chk({tag, "_done_low"},   32'(frame_done), 32'd0);
        chk({tag, "_rden_idle"},  32'(in_rd_en), 32'd1);
        chk({tag, "_no_accept"},  32'(out_valid), 32'd0);
    endtask

    initial begin
        Reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rden",  32'(in_rd_en), 32'd0);
        chk("rst_data",  32'(out_data), 32'd0);
        chk("rst_col",   32'(out_col), 32'd0);
        chk("rst_row",   32'(out_row), 32'd0);
        chk("rst_flags", 32'({out_sof, out_eol, out_eof}), 32'd0);
        chk("rst_done",  32'(frame_done), 32'd0);
        Reset = 1'b0;
        #1;
        chk("post_rst_rden", 32'(in_rd_en), 32'd1);

        // Frame 1: streaming, one pixel per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            chk_px("f1", i, i);
            if (i < 11) chk("f1_rden", 32'(in_rd_en), 32'd1);
        end
        flush_seq("f1");

        // Frame 2: downstream stall for 5 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        tick();
        chk_px("st_first", 0, 0);
        chk("st_rden1", 32'(in_rd_en), 32'd1);
        in_data = 8'h01;
        tick();
        chk("st_rden_full", 32'(in_rd_en), 32'd0);
        chk("st_hold_data", 32'(out_data), 32'd0);
        in_data = 8'h02;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("st_rden_hold", 32'(in_rd_en), 32'd0);
            chk("st_data_hold", 32'(out_data), 32'd0);
            chk("st_col_hold",  32'(out_col), 32'd0);
            chk("st_sof_hold",  32'(out_sof), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk_px("st_rel1", 1, 1);
        chk("st_rden_rel", 32'(in_rd_en), 32'd1);
        tick();
        chk_px("st_rel2", 2, 2);

        // Gapped input: indices keep advancing without holes
        in_valid = 1'b0;
        tick();
        chk("gap1_empty", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h03;
        tick();
        chk_px("gap_px3", 3, 3);
        in_valid = 1'b0;
        tick();
        chk("gap2_empty", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h04;
        tick();
        chk_px("gap_px4", 4, 4);
        for (int i = 5; i < 12; i++) begin
            in_data = 8'(i);
            tick();
            chk_px("f2", i, i);
        end
        flush_seq("f2");
        chk("done_count2", 32'(n_done), 32'd2);

        // Frame 3: reset after 6 accepts
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h20 + i);
            tick();
            chk_px("f3", 8'h20 + i, i);
        end
        Reset   = 1'b1;
        in_data = 8'h99;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_rden",  32'(in_rd_en), 32'd0);
        tick();
        Reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_after_valid", 32'(out_valid), 32'd0);
        chk("rst_after_data",  32'(out_data), 32'd0);
        tick();
        chk("rst_no_accept", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        chk_px("rst_px55", 8'h55, 0);
        in_valid = 1'b0;
        tick();
        chk("rst_px55_popped", 32'(out_valid), 32'd0);
        chk("done_count_final", 32'(n_done), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
